// File: rtl/buffer_arbiter.sv
// ============================================================================
// Module   : buffer_arbiter
// Purpose  : Runs a single-port sync-read byte RAM as a circular FIFO shared by
//            USB RX/TX byte ops and serialized 1/2/4-byte AHB store/get ops.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module buffer_arbiter #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_clear,
    input  logic [1:0]    i_ahb_store,
    input  logic [1:0]    i_ahb_get,
    input  logic [31:0]   i_ahb_wdata,
    output logic [31:0]   o_ahb_rdata,
    output logic          o_ahb_rvalid,
    output logic          o_ahb_busy,
    input  logic          i_usb_store,
    input  logic [7:0]    i_usb_wdata,
    input  logic          i_usb_get,
    output logic [7:0]    o_usb_rdata,
    output logic          o_usb_rvalid,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [7:0]    o_ram_wdata,
    input  logic [7:0]    i_ram_rdata,
    output logic [AW:0]   o_buffer_occupancy,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, AHB_WR, AHB_RD, RD_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_occ;
    logic          r_ovf, r_udf;
    logic [2:0]    r_len;
    logic [1:0]    r_idx;
    logic [31:0]   r_wdata, r_rdata;
    logic          r_cap_valid;
    logic [1:0]    r_cap_lane;
    logic          r_usb_rvalid, r_usb_rd_ok, r_rej_rvalid;

    logic          w_full, w_empty, w_usb_any, w_usb_st, w_usb_gt_req, w_usb_gt;
    logic          w_ahb_wr, w_ahb_rd, w_last, w_inc, w_dec;
    logic          w_acc_st, w_rej_st, w_acc_gt, w_rej_gt, w_idle_ok;
    logic [2:0]    w_st_len, w_gt_len;
    logic [AW:0]   w_free;
    logic [31:0]   w_rd_merged;

    function automatic logic [2:0] f_len(input logic [1:0] code);
        return (code == 2'd3) ? 3'd4 : {1'b0, code};
    endfunction

    // USB requests claim the RAM slot even when they end up doing nothing.
    assign w_full       = (r_occ == c_depth);
    assign w_empty      = (r_occ == '0);
    assign w_usb_any    = i_usb_store | i_usb_get;
    assign w_usb_st     = !i_clear && i_usb_store && !w_full;
    assign w_usb_gt_req = !i_clear && !i_usb_store && i_usb_get;
    assign w_usb_gt     = w_usb_gt_req && !w_empty;
    assign w_ahb_wr     = !i_clear && !w_usb_any && (r_state == AHB_WR);
    assign w_ahb_rd     = !i_clear && !w_usb_any && (r_state == AHB_RD);
    assign w_last       = ({1'b0, r_idx} == (r_len - 3'd1));
    assign w_inc        = w_usb_st | w_ahb_wr;
    assign w_dec        = w_usb_gt | w_ahb_rd;

    assign w_st_len  = f_len(i_ahb_store);
    assign w_gt_len  = f_len(i_ahb_get);
    assign w_free    = c_depth - r_occ;
    assign w_idle_ok = !i_clear && (r_state == IDLE);
    assign w_acc_st  = w_idle_ok && (i_ahb_store != 2'd0) && (w_free >= {{(AW-2){1'b0}}, w_st_len});
    assign w_rej_st  = w_idle_ok && (i_ahb_store != 2'd0) && (w_free <  {{(AW-2){1'b0}}, w_st_len});
    assign w_acc_gt  = w_idle_ok && (i_ahb_store == 2'd0) && (i_ahb_get != 2'd0)
                       && (r_occ >= {{(AW-2){1'b0}}, w_gt_len});
    assign w_rej_gt  = w_idle_ok && (i_ahb_store == 2'd0) && (i_ahb_get != 2'd0)
                       && (r_occ <  {{(AW-2){1'b0}}, w_gt_len});

    always_comb begin
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        if (w_usb_st) begin
            o_ram_we    = 1'b1;
            o_ram_addr  = r_wptr;
            o_ram_wdata = i_usb_wdata;
        end else if (w_usb_gt) begin
            o_ram_addr  = r_rptr;
        end else if (w_ahb_wr) begin
            o_ram_we    = 1'b1;
            o_ram_addr  = r_wptr;
            o_ram_wdata = r_wdata[8*r_idx +: 8];
        end else if (w_ahb_rd) begin
            o_ram_addr  = r_rptr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_acc_st) w_state_nxt = AHB_WR;
                          else if (w_acc_gt) w_state_nxt = AHB_RD;
                AHB_WR:   if (w_ahb_wr && w_last) w_state_nxt = IDLE;
                AHB_RD:   if (w_ahb_rd && w_last) w_state_nxt = RD_DRAIN;
                RD_DRAIN: w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    // The final read byte is still on i_ram_rdata during RD_DRAIN; merge it combinationally.
    always_comb begin
        w_rd_merged = r_rdata;
        if (r_cap_valid) w_rd_merged[8*r_cap_lane +: 8] = i_ram_rdata;
    end

    assign o_ahb_busy         = (r_state != IDLE);
    assign o_ahb_rvalid       = ((r_state == RD_DRAIN) && !i_clear) || r_rej_rvalid;
    assign o_ahb_rdata        = ((r_state == RD_DRAIN) && !i_clear) ? w_rd_merged : '0;
    assign o_usb_rvalid       = r_usb_rvalid;
    assign o_usb_rdata        = r_usb_rd_ok ? i_ram_rdata : 8'h00;
    assign o_buffer_occupancy = r_occ;
    assign o_overflow         = r_ovf;
    assign o_underflow        = r_udf;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
            r_len        <= '0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_lane   <= '0;
            r_usb_rvalid <= 1'b0;
            r_usb_rd_ok  <= 1'b0;
            r_rej_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_usb_rvalid <= w_usb_gt_req;
            r_usb_rd_ok  <= w_usb_gt;
            r_rej_rvalid <= w_rej_gt;
            r_cap_valid  <= w_ahb_rd;
            r_cap_lane   <= r_idx;
            if (r_cap_valid) r_rdata[8*r_cap_lane +: 8] <= i_ram_rdata;
            if (i_clear) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
                r_ovf  <= 1'b0;
                r_udf  <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_wptr <= r_wptr + AW'(w_inc);
                r_rptr <= r_rptr + AW'(w_dec);
                r_occ  <= r_occ + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
                if ((i_usb_store && w_full) || w_rej_st) r_ovf <= 1'b1;
                if ((w_usb_gt_req && w_empty) || w_rej_gt) r_udf <= 1'b1;
                if (w_ahb_wr || w_ahb_rd) r_idx <= r_idx + 2'd1;
                if (w_acc_st) begin
                    r_len   <= w_st_len;
                    r_wdata <= i_ahb_wdata;
                    r_idx   <= '0;
                end else if (w_acc_gt) begin
                    r_len   <= w_gt_len;
                    r_rdata <= '0;
                    r_idx   <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
// ============================================================================
// Module   : tb_buffer_arbiter
// Purpose  : Directed self-checking bench for buffer_arbiter with a behavioural
//            RAM and a byte-queue scoreboard of FIFO contents.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_buffer_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic [1:0]  ahb_store, ahb_get;
    logic [31:0] ahb_wdata, ahb_rdata;
    logic        ahb_rvalid, ahb_busy;
    logic        usb_store, usb_get, usb_rvalid;
    logic [7:0]  usb_wdata, usb_rdata;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [6:0]  occ;
    logic        overflow, underflow;

    logic [7:0]  mem [64];
    logic [7:0]  q [$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    buffer_arbiter #(.DEPTH(64)) dut (
        .clk(clk), .n_rst(n_rst), .i_clear(clear),
        .i_ahb_store(ahb_store), .i_ahb_get(ahb_get), .i_ahb_wdata(ahb_wdata),
        .o_ahb_rdata(ahb_rdata), .o_ahb_rvalid(ahb_rvalid), .o_ahb_busy(ahb_busy),
        .i_usb_store(usb_store), .i_usb_wdata(usb_wdata), .i_usb_get(usb_get),
        .o_usb_rdata(usb_rdata), .o_usb_rvalid(usb_rvalid),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_buffer_occupancy(occ),
        .o_overflow(overflow), .o_underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic usb_put(input logic [7:0] v);
        usb_store = 1'b1;
        usb_wdata = v;
        @(negedge clk);
        usb_store = 1'b0;
        if (q.size() < 64) q.push_back(v);
    endtask

    task automatic usb_take(input string tag);
        logic [7:0] exp;
        exp = (q.size() != 0) ? q.pop_front() : 8'h00;
        usb_get = 1'b1;
        @(negedge clk);
        usb_get = 1'b0;
        chk({tag, "_rvalid"}, 32'(usb_rvalid), 32'd1);
        chk({tag, "_rdata"}, 32'(usb_rdata), 32'(exp));
    endtask

    // Latency counts cycles from the request cycle (0) to the ahb_rvalid cycle.
    task automatic ahb_read(input string tag, input logic [1:0] code, input int nb,
                            input int stall, input int exp_lat);
        logic [31:0] exp, got;
        int          lat;
        exp = '0;
        got = '0;
        lat = -1;
        for (int b = 0; b < nb; b++) exp[8*b +: 8] = q.pop_front();
        ahb_get = code;
        @(negedge clk);
        ahb_get = 2'd0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (ahb_rvalid) begin
                lat = cyc;
                got = ahb_rdata;
                break;
            end
            usb_store = (cyc == stall);
            if (cyc == stall) begin
                usb_wdata = 8'h55;
                q.push_back(8'h55);
            end
            @(negedge clk);
        end
        usb_store = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0; clear = 1'b0; ahb_store = '0; ahb_get = '0; ahb_wdata = '0;
        usb_store = 1'b0; usb_get = 1'b0; usb_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_busy", 32'(ahb_busy), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("rst_rvalid", {30'd0, ahb_rvalid, usb_rvalid}, 32'd0);

        // 4-byte AHB store, one byte per cycle, little-endian
        ahb_store = 2'd3;
        ahb_wdata = 32'hDDCCBBAA;
        @(negedge clk);
        ahb_store = 2'd0;
        for (int i = 0; i < 4; i++) begin
            chk("ahbwr_we", 32'(ram_we), 32'd1);
            chk("ahbwr_addr", 32'(ram_addr), 32'(i));
            chk("ahbwr_data", 32'(ram_wdata), 32'(8'hAA + 8'(i * 8'h11)));
            q.push_back(8'(8'hAA + 8'(i * 8'h11)));
            @(negedge clk);
        end
        chk("ahbwr_occ", 32'(occ), 32'd4);
        chk("ahbwr_idle", 32'(ahb_busy), 32'd0);

        ahb_read("rd4", 2'd3, 4, 0, 5);
        chk("rd4_occ", 32'(occ), 32'd0);

        // AHB read preempted once by a USB store
        usb_put(8'h11); usb_put(8'h22); usb_put(8'h33); usb_put(8'h44);
        ahb_read("rd4_stall", 2'd3, 4, 2, 6);
        chk("stall_occ", 32'(occ), 32'd1);
        usb_take("take55");
        usb_put(8'h9A);
        ahb_read("rd1", 2'd1, 1, 0, 2);

        // Fill to full, then overflow
        for (int i = 0; i < 64; i++) usb_put(8'hA0 ^ 8'(i));
        chk("full_occ", 32'(occ), 32'd64);
        chk("full_ovf0", 32'(overflow), 32'd0);
        usb_put(8'hEE);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_occ", 32'(occ), 32'd64);
        ahb_store = 2'd1;
        @(negedge clk);
        ahb_store = 2'd0;
        chk("full_ahb_rej_busy", 32'(ahb_busy), 32'd0);
        chk("full_ahb_rej_occ", 32'(occ), 32'd64);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        q.delete();
        chk("clr_occ", 32'(occ), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Pointer wrap through 70 bytes
        for (int i = 0; i < 70; i++) begin
            usb_put(8'(i));
            usb_take("wrap");
        end
        chk("wrap_occ", 32'(occ), 32'd0);

        // Simultaneous store and get: store wins, get silently dropped
        usb_store = 1'b1; usb_get = 1'b1; usb_wdata = 8'h3C;
        @(negedge clk);
        usb_store = 1'b0; usb_get = 1'b0;
        q.push_back(8'h3C);
        chk("both_rvalid", 32'(usb_rvalid), 32'd0);
        chk("both_udf", 32'(underflow), 32'd0);
        chk("both_occ", 32'(occ), 32'd1);
        usb_take("both_take");

        // Get from empty
        usb_take("empty");
        chk("empty_udf", 32'(underflow), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_udf", 32'(underflow), 32'd0);

        // AHB 2-byte get with only 1 byte held
        usb_put(8'h77);
        ahb_get = 2'd2;
        @(negedge clk);
        ahb_get = 2'd0;
        chk("rej_rvalid", 32'(ahb_rvalid), 32'd1);
        chk("rej_rdata", ahb_rdata, 32'd0);
        chk("rej_udf", 32'(underflow), 32'd1);
        chk("rej_occ", 32'(occ), 32'd1);
        chk("rej_busy", 32'(ahb_busy), 32'd0);

        // Asynchronous reset in the middle of an AHB write
        ahb_store = 2'd3;
        ahb_wdata = 32'h01020304;
        @(negedge clk);
        ahb_store = 2'd0;
        chk("mid_busy", 32'(ahb_busy), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_busy", 32'(ahb_busy), 32'd0);
        chk("arst_occ", 32'(occ), 32'd0);
        chk("arst_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        q.delete();
        @(negedge clk);
        usb_take("post_rst_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
